// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter in front of a single-ported
// memory with a shared tristate data bus.
//
// Ports
//   clk, Reset                 clock, synchronous active-high reset
//   a_req/b_req                access request, held until the matching done
//   a_we/b_we                  1 = write, 0 = read (sampled at grant)
//   a_addr/b_addr              word address (sampled at grant)
//   a_wdata/b_wdata            write data (sampled at grant)
//   a_gnt/b_gnt                one-cycle acceptance pulse
//   a_done/b_done              one-cycle completion pulse
//   a_err/b_err                pulses with done for an out-of-range address
//   a_rdata/b_rdata            last read result for that port
//   mem_address                memory word address
//   mem_nEnable                memory enable, active-low
//   mem_ReadWrite              1 = read, 0 = write
//   mem_dataBus                shared tristate memory data bus
//
// Timing (gnt visible in cycle T): write done at T+2, read done at T+3,
// out-of-range done at T+1. All outputs come straight from flops.
module mem_arbiter #(
  parameter int unsigned DATA_W = 256,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 8
) (
  input  logic              clk,
  input  logic              Reset,

  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_done,
  output logic              a_err,
  output logic [DATA_W-1:0] a_rdata,

  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_done,
  output logic              b_err,
  output logic [DATA_W-1:0] b_rdata,

  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_nEnable,
  output logic              mem_ReadWrite,
  inout  wire  [DATA_W-1:0] mem_dataBus
);

  // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
  localparam int unsigned        LIM_W     = ADDR_W + 1;
  localparam logic [LIM_W-1:0]   DEPTH_LIM = LIM_W'(DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD0,
    ST_RD1,
    ST_DONE
  } state_e;

  state_e              state_q, state_d;
  logic                prio_b_q, prio_b_d;   // 1: B wins the next contention
  logic                sel_b_q, sel_b_d;     // port owning the current access
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                oor_q, oor_d;         // latched address-out-of-range

  logic                a_gnt_q, a_gnt_d;
  logic                b_gnt_q, b_gnt_d;
  logic                a_done_q, a_done_d;
  logic                b_done_q, b_done_d;
  logic                a_err_q, a_err_d;
  logic                b_err_q, b_err_d;
  logic [DATA_W-1:0]   a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0]   b_rdata_q, b_rdata_d;

  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                mem_nen_q, mem_nen_d;
  logic                mem_rw_q, mem_rw_d;
  logic                mem_oe_q, mem_oe_d;

  // A port whose done is showing this cycle still has its old request up
  // (the requester only drops it next cycle), so it is not eligible yet.
  logic                a_elig;
  logic                b_elig;
  logic                pick_b;
  logic [ADDR_W-1:0]   sel_addr;
  logic                sel_oor;

  assign a_elig   = a_req && !a_done_q;
  assign b_elig   = b_req && !b_done_q;
  assign pick_b   = b_elig && (!a_elig || prio_b_q);
  assign sel_addr = pick_b ? b_addr : a_addr;
  assign sel_oor  = {1'b0, sel_addr} >= DEPTH_LIM;

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_d    = state_q;
    prio_b_d   = prio_b_q;
    sel_b_d    = sel_b_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    oor_d      = oor_q;
    a_gnt_d    = 1'b0;
    b_gnt_d    = 1'b0;
    a_done_d   = 1'b0;
    b_done_d   = 1'b0;
    a_err_d    = 1'b0;
    b_err_d    = 1'b0;
    a_rdata_d  = a_rdata_q;
    b_rdata_d  = b_rdata_q;
    mem_addr_d = '0;
    mem_nen_d  = 1'b1;
    mem_rw_d   = 1'b1;
    mem_oe_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (a_elig || b_elig) begin
          sel_b_d  = pick_b;
          prio_b_d = !pick_b;
          a_gnt_d  = !pick_b;
          b_gnt_d  = pick_b;
          we_d     = pick_b ? b_we : a_we;
          addr_d   = sel_addr;
          wdata_d  = pick_b ? b_wdata : a_wdata;
          oor_d    = sel_oor;
          if (sel_oor) begin
            state_d = ST_DONE;
          end else if (we_d) begin
            state_d = ST_WR;
          end else begin
            state_d = ST_RD0;
          end
        end
      end
      ST_WR:  state_d = ST_DONE;
      ST_RD0: state_d = ST_RD1;
      ST_RD1: begin
        // Bus is sampled at the closing edge of RD1.
        if (sel_b_q) begin
          b_rdata_d = mem_dataBus;
        end else begin
          a_rdata_d = mem_dataBus;
        end
        state_d = ST_DONE;
      end
      ST_DONE: begin
        a_done_d = !sel_b_q;
        b_done_d = sel_b_q;
        a_err_d  = !sel_b_q && oor_q;
        b_err_d  = sel_b_q && oor_q;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Memory pins follow the state being entered so they line up with it.
    if (state_d == ST_WR || state_d == ST_RD0 || state_d == ST_RD1) begin
      mem_addr_d = addr_d;
      mem_nen_d  = 1'b0;
      mem_rw_d   = (state_d != ST_WR);
      mem_oe_d   = (state_d == ST_WR);
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      prio_b_q   <= 1'b0;
      sel_b_q    <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      oor_q      <= 1'b0;
      a_gnt_q    <= 1'b0;
      b_gnt_q    <= 1'b0;
      a_done_q   <= 1'b0;
      b_done_q   <= 1'b0;
      a_err_q    <= 1'b0;
      b_err_q    <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
      mem_addr_q <= '0;
      mem_nen_q  <= 1'b1;
      mem_rw_q   <= 1'b1;
      mem_oe_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      prio_b_q   <= prio_b_d;
      sel_b_q    <= sel_b_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      oor_q      <= oor_d;
      a_gnt_q    <= a_gnt_d;
      b_gnt_q    <= b_gnt_d;
      a_done_q   <= a_done_d;
      b_done_q   <= b_done_d;
      a_err_q    <= a_err_d;
      b_err_q    <= b_err_d;
      a_rdata_q  <= a_rdata_d;
      b_rdata_q  <= b_rdata_d;
      mem_addr_q <= mem_addr_d;
      mem_nen_q  <= mem_nen_d;
      mem_rw_q   <= mem_rw_d;
      mem_oe_q   <= mem_oe_d;
    end
  end

  // Bus is only driven in WR, where ReadWrite is 0 and nEnable is 0.
  assign mem_dataBus   = mem_oe_q ? wdata_q : {DATA_W{1'bz}};

  assign a_gnt         = a_gnt_q;
  assign b_gnt         = b_gnt_q;
  assign a_done        = a_done_q;
  assign b_done        = b_done_q;
  assign a_err         = a_err_q;
  assign b_err         = b_err_q;
  assign a_rdata       = a_rdata_q;
  assign b_rdata       = b_rdata_q;
  assign mem_address   = mem_addr_q;
  assign mem_nEnable   = mem_nen_q;
  assign mem_ReadWrite = mem_rw_q;

endmodule
